// File: rtl/decoder_3to8_using_2to4.sv
// decoder_3to8_using_2to4
// Registered 3-to-8 one-hot decoder built from two 2-to-4 decoders.
// The low instance covers codes 0..3, the high instance codes 4..7; i[2]
// steers the enable between them.
//
// Output protocol: valid is a qualifier, not a handshake. There is no ready,
// and the consumer cannot stall the decoder. In the same cycle that valid is
// high, d holds the decode of an enabled input. In the same cycle that valid
// is low, d holds the inactive value. d and valid always update on the same
// edge.
//
// OUT_ACTIVE_LOW = 1 inverts every bit of d, including the reset value.
//
// Optional build macro DEC_ONEHOT_CHECK_EN adds the err output and a
// checker. The checker watches the registered d. It raises err when
// normalised d is not one-hot while valid is high, or not all-zero while
// valid is low. err then stays high until the next reset.

module decoder_2to4 (
  output logic [3:0] y,
  input  logic [1:0] a,
  input  logic       e
);

  // One-hot decode of a, forced to zero when e is low.
  always_comb begin
    y = 4'b0000;
    if (e) begin
      y[a] = 1'b1;
    end
  end

endmodule

module decoder_3to8_using_2to4 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  output logic [7:0] d,
  input  logic [2:0] i,
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       valid
`ifdef DEC_ONEHOT_CHECK_EN
  ,
  output logic       err
`endif
);

  // XOR mask that maps the active-high decode onto the output polarity.
  localparam logic [7:0] INV_MASK = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] d_next;
  logic       lo_en;
  logic       hi_en;

  assign lo_en = en & ~i[2];
  assign hi_en = en & i[2];

  decoder_2to4 u_dec_lo (
    .y (d_next[3:0]),
    .a (i[1:0]),
    .e (lo_en)
  );

  decoder_2to4 u_dec_hi (
    .y (d_next[7:4]),
    .a (i[1:0]),
    .e (hi_en)
  );

  // Output register. Reset loads the inactive value and drops valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d     <= INV_MASK;
      valid <= 1'b0;
    end else begin
      d     <= d_next ^ INV_MASK;
      valid <= en;
    end
  end

`ifdef DEC_ONEHOT_CHECK_EN
  logic [7:0] d_norm;
  logic       d_onehot;
  logic       d_bad;

  // Normalise d to active-high, then test it against what valid implies.
  always_comb begin
    d_norm   = d ^ INV_MASK;
    d_onehot = (d_norm != 8'h00) && ((d_norm & (d_norm - 8'd1)) == 8'h00);
    d_bad    = valid ? ~d_onehot : (d_norm != 8'h00);
  end

  // Sticky violation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= err | d_bad;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_3to8_using_2to4.sv
// tb_decoder_3to8_using_2to4
// Drives one active-high instance and one active-low instance of the
// decoder from the same inputs. Every result is compared with a
// reference value that the bench computes from the select code.

module tb_decoder_3to8_using_2to4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] i;
  logic [7:0] d_hi;
  logic [7:0] d_lo;
  logic       valid_hi;
  logic       valid_lo;
`ifdef DEC_ONEHOT_CHECK_EN
  logic       err_hi;
  logic       err_lo;
`endif

  int tests_run;
  int tests_failed;

  logic [7:0] exp_q[$];
  logic       exp_v_q[$];

  decoder_3to8_using_2to4 #(.OUT_ACTIVE_LOW(1'b0)) dut (
    .d     (d_hi),
    .i     (i),
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .valid (valid_hi)
`ifdef DEC_ONEHOT_CHECK_EN
    ,
    .err   (err_hi)
`endif
  );

  decoder_3to8_using_2to4 #(.OUT_ACTIVE_LOW(1'b1)) dut_al (
    .d     (d_lo),
    .i     (i),
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .valid (valid_lo)
`ifdef DEC_ONEHOT_CHECK_EN
    ,
    .err   (err_lo)
`endif
  );

  // Clock and reset defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: one bit at position sel when enabled, otherwise nothing.
  function automatic logic [7:0] model_d(input logic e, input logic [2:0] sel);
    int pos;
    pos = sel;
    return e ? 8'((1 << pos)) : 8'h00;
  endfunction

  // Advance one edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check both instances against one active-high expectation.
  task automatic check_both(input string name, input logic [7:0] exp_d, input logic exp_v);
    tests_run++;
    if (d_hi !== exp_d || valid_hi !== exp_v) begin
      tests_failed++;
      $display("FAIL %s (high): d=%h valid=%b, required d=%h valid=%b", name, d_hi, valid_hi, exp_d, exp_v);
    end
    tests_run++;
    if (d_lo !== ~exp_d || valid_lo !== exp_v) begin
      tests_failed++;
      $display("FAIL %s (low): d=%h valid=%b, required d=%h valid=%b", name, d_lo, valid_lo, ~exp_d, exp_v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    i     = 3'b101;
    tick();
    tick();
    check_both("reset", 8'h00, 1'b0);
`ifdef DEC_ONEHOT_CHECK_EN
    tests_run++;
    if (err_hi !== 1'b0 || err_lo !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_err: err=%b/%b, required 0/0", err_hi, err_lo);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    for (int k = 0; k < 8; k++) begin
      en = 1'b1;
      i  = 3'(k);
      tick();
      check_both($sformatf("sweep_%0d", k), model_d(1'b1, 3'(k)), 1'b1);
`ifdef DEC_ONEHOT_CHECK_EN
      tests_run++;
      if (err_hi !== 1'b0 || err_lo !== 1'b0) begin
        tests_failed++;
        $display("FAIL sweep_err_%0d: err=%b/%b, required 0/0", k, err_hi, err_lo);
      end
`endif
    end
  endtask

  task automatic test_disable();
    en = 1'b0;
    i  = 3'b011;
    tick();
    check_both("disable", 8'h00, 1'b0);
    en = 1'b1;
    tick();
    check_both("reenable", 8'h08, 1'b1);
  endtask

  task automatic test_active_low();
    en = 1'b1;
    i  = 3'b110;
    tick();
    tests_run++;
    if (d_lo !== 8'hBF) begin
      tests_failed++;
      $display("FAIL active_low_6: d=%h, required bf", d_lo);
    end
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (d_lo !== 8'hFF || valid_lo !== 1'b0) begin
      tests_failed++;
      $display("FAIL active_low_reset: d=%h valid=%b, required ff 0", d_lo, valid_lo);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midstream();
    en = 1'b1;
    i  = 3'b111;
    tick();
    check_both("mid_pre", 8'h80, 1'b1);
    rst_n = 1'b0;
    tick();
    check_both("mid_reset", 8'h00, 1'b0);
    rst_n = 1'b1;
    en    = 1'b0;
    tick();
    check_both("mid_release", 8'h00, 1'b0);
    en = 1'b1;
    i  = 3'b010;
    tick();
    check_both("mid_first", 8'h04, 1'b1);
  endtask

  // Random back-to-back traffic, scored through an expected queue.
  task automatic test_back_to_back();
    logic [7:0] exp_d;
    logic       exp_v;
    for (int n = 0; n < 200; n++) begin
      en = ($urandom_range(0, 3) != 0);
      i  = 3'($urandom_range(0, 7));
      exp_q.push_back(model_d(en, i));
      exp_v_q.push_back(en);
      tick();
      exp_d = exp_q.pop_front();
      exp_v = exp_v_q.pop_front();
      check_both($sformatf("random_%0d", n), exp_d, exp_v);
    end
  endtask

`ifdef DEC_ONEHOT_CHECK_EN
  task automatic test_onehot_check();
    en = 1'b1;
    i  = 3'b001;
    tick();
    force dut.d = 8'h03;
    tick();
    release dut.d;
    tick();
    tests_run++;
    if (err_hi !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_set: err=%b, required 1", err_hi);
    end
    tick();
    tests_run++;
    if (err_hi !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: err=%b, required 1", err_hi);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++;
    if (err_hi !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clear: err=%b, required 0", err_hi);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    i     = 3'b000;
    test_reset();
    test_sweep();
    test_disable();
    test_active_low();
    test_reset_midstream();
    test_back_to_back();
`ifdef DEC_ONEHOT_CHECK_EN
    test_onehot_check();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
